// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM state type, accumulator sizing and saturation helpers for the CNN datapath
package cnn_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int acc_w(int data_w, int coef_w, int ch);
    return data_w + coef_w + 1 + $clog2(9 * ch) + 1;
  endfunction
  function automatic longint sat_u(longint v, int w);
    longint hi;
    hi = (longint'(1) << w) - 64'sd1;
    return v < 64'sd0 ? 64'sd0 : (v > hi ? hi : v);
  endfunction
  function automatic longint sat_s(longint v, int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: enable-gated shift register delaying a pixel word by DEPTH accepted beats
module line_buffer #(
  parameter int DEPTH = 31,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [DEPTH];
  // shift one position per accepted pixel; contents need no reset
  always_ff @(posedge clk)
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid-mode multi-channel convolution with bias, ReLU/saturation and valid/ready flow control
module conv3x3_stream
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int CH     = 3,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  parameter int RELU   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         coef_we,
  input  logic [$clog2(CH*9+1)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]     coef_wdata,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH*DATA_W-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic                         busy,
  output logic                         frame_done
);
  localparam int NCOEF = CH * 9;
  localparam int AW    = $clog2(CH * 9 + 1);
  localparam int PW    = DATA_W + COEF_W + 1;
  localparam int ACC_W = acc_w(DATA_W, COEF_W, CH);
  localparam int PIX_W = CH * DATA_W;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [COEF_W-1:0] coef [NCOEF+1];
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic signed [PW-1:0] prod [NCOEF];
  logic signed [ACC_W-1:0] acc;
  logic v1, v2, advance, accept, last_pix, col_end, drained;

  assign advance  = !out_valid || out_ready;
  assign in_ready = state == RUN && advance;
  assign accept   = in_valid && in_ready;
  assign col_end  = col == CW'(IMG_W - 1);
  assign last_pix = col_end && row == RW'(IMG_H - 1);
  assign drained  = !v1 && !v2 && advance;
  assign busy     = state != IDLE;

  // window column i=row-offset feeds from the previous row's delayed word, so the cascade depth IMG_W-1 plus the window register spans one row
  line_buffer #(.DEPTH(IMG_W - 1), .W(PIX_W)) u_lb0 (.clk(clk), .en(accept), .din(win[2][2]), .dout(lb0_q));
  line_buffer #(.DEPTH(IMG_W - 1), .W(PIX_W)) u_lb1 (.clk(clk), .en(accept), .din(win[1][2]), .dout(lb1_q));

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // next-state: start a frame, drain after the last pixel, return when the pipeline is empty
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = accept && last_pix ? DRAIN : RUN;
      DRAIN:   state_n = drained ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end

  // coefficient bank, writable only while idle so a frame always sees one consistent set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k <= NCOEF; k++) coef[k] <= '0;
    else if (state == IDLE && coef_we && coef_addr <= AW'(NCOEF)) coef[coef_addr] <= coef_wdata;

  // S1 window shift on accept and S2 products on advance; datapath needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[2][2] <= in_data;
      win[1][2] <= lb0_q;
      win[0][2] <= lb1_q;
    end
    if (advance)
      for (int k = 0; k < CH; k++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            prod[k*9+i*3+j] <= PW'($signed({1'b0, win[i][j][k*DATA_W +: DATA_W]})) * PW'(coef[k*9+i*3+j]);
  end

  // S3 adder tree with the bias added last
  always_comb begin
    acc = '0;
    for (int k = 0; k < NCOEF; k++) acc = acc + ACC_W'(prod[k]);
    acc = acc + ACC_W'(coef[NCOEF]);
  end

  // pixel counters, pipeline valid bits, output register and completion pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= state == DRAIN && drained;
      if (state == IDLE && start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        col <= col_end ? '0 : col + 1'b1;
        row <= col_end ? (row == RW'(IMG_H - 1) ? '0 : row + 1'b1) : row;
      end
      if (advance) begin
        v1        <= accept && row >= RW'(2) && col >= CW'(2);
        v2        <= v1;
        out_valid <= v2;
        if (v2) out_data <= OUT_W'(RELU != 0 ? sat_u(64'(acc), OUT_W) : sat_s(64'(acc), OUT_W));
      end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: directed and randomized checks of conv3x3_stream (ReLU and signed builds) against an arithmetic reference model
module tb_conv3x3_stream;
  localparam int W = 8, H = 6, CH = 3, DW = 8, CWD = 8, OW = 8;
  localparam int NPIX = W * H, NOUT = (W - 2) * (H - 2), NC = CH * 9, AW = $clog2(NC + 1);

  logic clk = 0, rst_n = 1;
  logic coef_we = 0, start = 0, in_valid = 0, out_ready = 1;
  logic [AW-1:0] coef_addr = '0;
  logic [CWD-1:0] coef_wdata = '0;
  logic [CH*DW-1:0] in_data = '0;
  logic in_ready_u, out_valid_u, busy_u, frame_done_u;
  logic in_ready_s, out_valid_s, busy_s, frame_done_s;
  logic [OW-1:0] out_data_u, out_data_s;

  int checks = 0, errors = 0;
  int coefm [NC+1];
  int img [H][W][CH];
  int exp_u [$], exp_s [$];
  longint first_u, last_u, last_s;

  always #5 clk = ~clk;

  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .CH(CH), .DATA_W(DW), .COEF_W(CWD), .OUT_W(OW), .RELU(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .start(start), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u), .busy(busy_u), .frame_done(frame_done_u));

  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .CH(CH), .DATA_W(DW), .COEF_W(CWD), .OUT_W(OW), .RELU(0)) u_sgn (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .start(start), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .busy(busy_s), .frame_done(frame_done_s));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready_u, 0);
    chk({tag, "_out_valid"}, out_valid_u, 0);
    chk({tag, "_out_data_u"}, out_data_u, 0);
    chk({tag, "_out_data_s"}, out_data_s, 0);
    chk({tag, "_busy"}, busy_u | busy_s, 0);
    chk({tag, "_frame_done"}, frame_done_u | frame_done_s, 0);
  endtask

  function automatic int clamp(int v, int lo, int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction

  task automatic make_image(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < CH; k++)
          case (mode)
            0:       img[r][c][k] = $urandom_range(0, 255);
            1:       img[r][c][k] = 255;
            2:       img[r][c][k] = (r * W + c) % 256;
            default: img[r][c][k] = $urandom_range(0, 31);
          endcase
  endtask

  task automatic build_expected();
    int s;
    exp_u.delete();
    exp_s.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        s = 0;
        for (int k = 0; k < CH; k++)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              s += img[r-2+i][c-2+j][k] * coefm[k*9+i*3+j];
        s += coefm[NC];
        exp_u.push_back(clamp(s, 0, (1 << OW) - 1));
        exp_s.push_back(clamp(s, -(1 << (OW - 1)), (1 << (OW - 1)) - 1));
      end
  endtask

  function automatic logic [CH*DW-1:0] pix(int n);
    logic [CH*DW-1:0] v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = DW'(img[n / W][n % W][k]);
    return v;
  endfunction

  task automatic write_coef(input int a, input int v);
    @(negedge clk);
    coef_we = 1;
    coef_addr = AW'(a);
    coef_wdata = CWD'(v);
    coefm[a] = v;
    @(negedge clk);
    coef_we = 0;
  endtask

  task automatic load_coefs(input int mode);
    int v;
    for (int a = 0; a <= NC; a++) begin
      case (mode)
        1:       v = a == NC ? 0 : 127;
        2:       v = a == NC ? -128 : 0;
        3:       v = a == NC ? 0 : -128;
        4:       v = a == NC ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 6)) - 3;
        5:       v = a == 4 ? 1 : 0;
        default: v = 0;
      endcase
      write_coef(a, v);
    end
  endtask

  task automatic run_frame(input int mode, input bit bp, input int abort_at, input bit run_write);
    int sent, got, cyc, eu, es;
    bit done, stall_prev;
    logic [OW-1:0] held_u, held_s;
    make_image(mode);
    build_expected();
    sent = 0; got = 0; cyc = 0; done = 0; stall_prev = 0; held_u = '0; held_s = '0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy_u, 1);
    while (cyc < 4000) begin
      if (stall_prev) begin
        chk("hold_valid", out_valid_u, 1);
        chk("hold_data_u", out_data_u, held_u);
        chk("hold_data_s", out_data_s, held_s);
      end
      if (frame_done_u) begin
        chk("done_outputs", got, NOUT);
        chk("done_pixels", sent, NPIX);
        chk("done_sgn", frame_done_s, 1);
        done = 1;
        break;
      end
      if (abort_at >= 0 && sent == abort_at) break;
      out_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid   = sent < NPIX && (!bp || $urandom_range(0, 3) != 0);
      in_data    = sent < NPIX ? pix(sent) : '0;
      coef_we    = run_write && sent == 10;
      coef_addr  = AW'(NC);
      coef_wdata = CWD'(100);
      #1;
      chk("in_ready_match", in_ready_s, in_ready_u);
      if (out_valid_u && out_ready) begin
        chk("out_pending", exp_u.size() > 0, 1);
        if (exp_u.size() > 0) begin
          eu = exp_u.pop_front();
          es = exp_s.pop_front();
          chk("out_u", out_data_u, eu);
          chk("out_s", $signed(out_data_s), es);
          chk("valid_s", out_valid_s, 1);
          if (got == 0) first_u = out_data_u;
          last_u = out_data_u;
          last_s = $signed(out_data_s);
          got++;
        end
      end
      if (in_valid && in_ready_u) sent++;
      stall_prev = out_valid_u && !out_ready;
      held_u = out_data_u;
      held_s = out_data_s;
      cyc++;
      @(negedge clk);
    end
    in_valid = 0;
    coef_we = 0;
    out_ready = 1;
    if (abort_at < 0) begin
      chk("frame_done_seen", done, 1);
      chk("all_outputs", got, NOUT);
      chk("idle_after_done", busy_u, 0);
    end
  endtask

  initial begin
    #2 rst_n = 0;
    #1 chk_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int a = 0; a <= NC; a++) coefm[a] = 0;

    load_coefs(5);
    run_frame(2, 0, -1, 0);
    chk("ident_first", first_u, W + 1);
    chk("ident_last", last_s, (H - 2) * W + (W - 2));

    load_coefs(1);
    run_frame(1, 0, -1, 0);
    chk("sat_hi_u", last_u, 255);
    chk("sat_hi_s", last_s, 127);

    load_coefs(2);
    run_frame(0, 0, -1, 0);
    chk("bias_neg_u", last_u, 0);
    chk("bias_neg_s", last_s, -128);

    load_coefs(3);
    run_frame(1, 0, -1, 0);
    chk("neg_u", last_u, 0);
    chk("neg_s", last_s, -128);

    load_coefs(4);
    run_frame(3, 1, -1, 0);
    run_frame(0, 1, -1, 0);
    run_frame(3, 0, -1, 0);

    run_frame(3, 1, -1, 1);
    write_coef(NC, 100);
    run_frame(3, 1, -1, 0);

    run_frame(3, 1, 40, 0);
    rst_n = 0;
    #1 chk_reset("mid");
    @(negedge clk);
    rst_n = 1;
    for (int a = 0; a <= NC; a++) coefm[a] = 0;
    run_frame(0, 1, -1, 0);
    chk("coef_reset_s", last_s, 0);
    load_coefs(4);
    run_frame(3, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
